controle_entrada_saida: RTL and testbench



---
 rtl/controle_es_pkg.sv | 10 +
 rtl/debounce_botao.sv | 33 +++
 rtl/controle_entrada_saida.sv | 88 ++++++++
 tb/tb_controle_entrada_saida.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/controle_es_pkg.sv
// controle_es_pkg: shared FSM state type and default datapath width for controle_entrada_saida
package controle_es_pkg;
    typedef enum logic [1:0] {
        OCIOSO           = 2'd0,
        ESPERA_SOLTO     = 2'd1,
        ESPERA_PRESSIONA = 2'd2,
        CAPTURA          = 2'd3
    } estado_t;
    localparam int LARGURA_DADO_PADRAO = 32;
endpackage

// File: rtl/debounce_botao.sv
// debounce_botao: 2-flop synchronizer plus consecutive-cycle debounce counter for the confirm button
module debounce_botao #(
    parameter int DEBOUNCE_CICLOS = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic botao,
    output logic nivel
);
    localparam int CW = $clog2(DEBOUNCE_CICLOS + 1);
    localparam logic [CW-1:0] LIMITE = CW'(DEBOUNCE_CICLOS - 1);
    logic [1:0]    sinc_q;
    logic [CW-1:0] cont_q, cont_d;
    logic          nivel_q, nivel_d;
    logic          difere;
    always_comb begin
        difere  = sinc_q[1] != nivel_q;
        cont_d  = (difere && cont_q != LIMITE) ? cont_q + 1'b1 : '0;
        nivel_d = (difere && cont_q == LIMITE) ? sinc_q[1] : nivel_q;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            sinc_q  <= '0;
            cont_q  <= '0;
            nivel_q <= 1'b0;
        end else begin
            sinc_q  <= {sinc_q[0], botao};
            cont_q  <= cont_d;
            nivel_q <= nivel_d;
        end
    end
    assign nivel = nivel_q;
endmodule

// File: rtl/controle_entrada_saida.sv
// controle_entrada_saida: input/out instruction I/O controller; CONTROLE_ES_CONTADOR_EN adds in/out counters
module controle_entrada_saida
    import controle_es_pkg::*;
#(
    parameter int DEBOUNCE_CICLOS = 50000,
    parameter int LARGURA_CHAVES  = 16,
    parameter int LARGURA_DADO    = LARGURA_DADO_PADRAO
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      inp,
    input  logic                      out,
    input  logic                      botao,
    input  logic [LARGURA_CHAVES-1:0] chaves,
    input  logic [LARGURA_DADO-1:0]   dado_saida,
    output logic                      pausa,
    output logic                      escreve_entrada,
    output logic [LARGURA_DADO-1:0]   dado_entrada,
    output logic [LARGURA_DADO-1:0]   display,
    output logic                      display_valido
`ifdef CONTROLE_ES_CONTADOR_EN
    ,
    output logic [7:0]                contador_saidas,
    output logic [7:0]                contador_entradas
`endif
);
    estado_t                 estado_q, estado_d;
    logic [LARGURA_DADO-1:0] dado_entrada_q, dado_entrada_d;
    logic [LARGURA_DADO-1:0] display_q, display_d;
    logic                    valido_q, valido_d;
    logic                    nivel, captura, aceita_saida;

    debounce_botao #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_debounce (
        .clock(clock),
        .reset(reset),
        .botao(botao),
        .nivel(nivel)
    );

    always_comb begin
        // reset gates pausa so the PC is never held while the controller is being cleared
        pausa = !reset && ((estado_q == OCIOSO && inp) || estado_q == ESPERA_SOLTO ||
                           estado_q == ESPERA_PRESSIONA);
        captura        = estado_q == ESPERA_PRESSIONA && nivel;
        aceita_saida   = out && !pausa;
        estado_d       = (estado_q == OCIOSO)       ? (inp ? ESPERA_SOLTO : OCIOSO) :
                         (estado_q == ESPERA_SOLTO) ? (nivel ? ESPERA_SOLTO : ESPERA_PRESSIONA) :
                         captura                    ? CAPTURA :
                         (estado_q == ESPERA_PRESSIONA) ? ESPERA_PRESSIONA : OCIOSO;
        dado_entrada_d = captura ? LARGURA_DADO'(chaves) : dado_entrada_q;
        display_d      = aceita_saida ? dado_saida : display_q;
        valido_d       = valido_q || aceita_saida;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q       <= OCIOSO;
            dado_entrada_q <= '0;
            display_q      <= '0;
            valido_q       <= 1'b0;
        end else begin
            estado_q       <= estado_d;
            dado_entrada_q <= dado_entrada_d;
            display_q      <= display_d;
            valido_q       <= valido_d;
        end
    end

    assign escreve_entrada = estado_q == CAPTURA;
    assign dado_entrada    = dado_entrada_q;
    assign display         = display_q;
    assign display_valido  = valido_q;

`ifdef CONTROLE_ES_CONTADOR_EN
    logic [7:0] cont_saidas_q, cont_entradas_q;
    always_ff @(posedge clock) begin
        if (reset) begin
            cont_saidas_q   <= '0;
            cont_entradas_q <= '0;
        end else begin
            cont_saidas_q   <= cont_saidas_q + {7'd0, aceita_saida};
            cont_entradas_q <= cont_entradas_q + {7'd0, captura};
        end
    end
    assign contador_saidas   = cont_saidas_q;
    assign contador_entradas = cont_entradas_q;
`endif
endmodule

// File: tb/tb_controle_entrada_saida.sv
// tb_controle_entrada_saida: vector table, hand sequences and random traffic against a behavioural model
module tb_controle_entrada_saida;
    localparam int N = 4;
    logic        clock = 1'b0;
    logic        reset, inp, out, botao;
    logic [15:0] chaves;
    logic [31:0] dado_saida;
    logic        pausa, escreve_entrada, display_valido;
    logic [31:0] dado_entrada, display;
`ifdef CONTROLE_ES_CONTADOR_EN
    logic [7:0]  contador_saidas, contador_entradas;
`endif
    int n_chk = 0;
    int n_fail = 0;
    int n_pulsos = 0;
    bit chk_on = 0;

    always #5 clock = ~clock;

    controle_entrada_saida #(.DEBOUNCE_CICLOS(N), .LARGURA_CHAVES(16), .LARGURA_DADO(32)) dut (
        .clock(clock),
        .reset(reset),
        .inp(inp),
        .out(out),
        .botao(botao),
        .chaves(chaves),
        .dado_saida(dado_saida),
        .pausa(pausa),
        .escreve_entrada(escreve_entrada),
        .dado_entrada(dado_entrada),
        .display(display),
        .display_valido(display_valido)
`ifdef CONTROLE_ES_CONTADOR_EN
        ,
        .contador_saidas(contador_saidas),
        .contador_entradas(contador_entradas)
`endif
    );

    task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nome, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic espera_escrita(input int limite, output int lat);
        lat = -1;
        for (int i = 1; i <= limite; i++) begin
            tick();
            if (escreve_entrada) begin
                lat = i;
                break;
            end
        end
    endtask

    // Behavioural model: an `input` is pending until a release and then a press of the debounced
    // button are seen; the debounced level follows the last N synchronized samples when all agree.
    logic        m_ativo, m_solto, m_cap, m_niv, m_val;
    logic [31:0] m_din, m_disp;
    logic        bh[3];
    logic        sh[N];
    int          m_cs, m_ce;

    always @(posedge clock) begin : modelo
        logic p, s, todos;
        if (reset) begin
            m_ativo = 0; m_solto = 0; m_cap = 0; m_niv = 0; m_val = 0;
            m_din = 0; m_disp = 0; m_cs = 0; m_ce = 0;
            for (int i = 0; i < 3; i++) bh[i] = 0;
            for (int i = 0; i < N; i++) sh[i] = 0;
        end else begin
            p = m_ativo || (!m_cap && inp);
            if (out && !p) begin
                m_disp = dado_saida;
                m_val = 1;
                m_cs = (m_cs + 1) % 256;
            end
            if (m_cap) m_cap = 0;
            else if (!m_ativo) begin
                if (inp) begin m_ativo = 1; m_solto = 0; end
            end else if (!m_solto) m_solto = !m_niv;
            else if (m_niv) begin
                m_ativo = 0;
                m_cap = 1;
                m_din = {16'h0, chaves};
                m_ce = (m_ce + 1) % 256;
            end
            bh[2] = bh[1]; bh[1] = bh[0]; bh[0] = botao;
            s = bh[2];
            for (int i = N - 1; i > 0; i--) sh[i] = sh[i-1];
            sh[0] = s;
            todos = 1;
            for (int i = 0; i < N; i++) if (sh[i] == m_niv) todos = 0;
            if (todos) m_niv = s;
        end
    end

    always @(negedge clock) begin
        if (chk_on) begin
            chk("modelo_pausa", 32'(pausa), 32'(!reset && (m_ativo || (!m_cap && inp))));
            chk("modelo_escreve", 32'(escreve_entrada), 32'(m_cap));
            chk("modelo_dado_entrada", dado_entrada, m_din);
            chk("modelo_display", display, m_disp);
            chk("modelo_valido", 32'(display_valido), 32'(m_val));
`ifdef CONTROLE_ES_CONTADOR_EN
            chk("modelo_cont_saidas", 32'(contador_saidas), m_cs);
            chk("modelo_cont_entradas", 32'(contador_entradas), m_ce);
`endif
            if (escreve_entrada) n_pulsos++;
        end
    end

    typedef struct {
        logic        inp;
        logic        out;
        logic [31:0] dado;
        logic        pausa;
        logic [31:0] disp;
        logic        valido;
    } vet_t;
    vet_t vt[6];

    initial begin
        int lat, lat2, p0;
        vt[0] = '{1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b1};
        vt[1] = '{1'b0, 1'b0, 32'h12345678, 1'b0, 32'hDEADBEEF, 1'b1};
        vt[2] = '{1'b0, 1'b1, 32'h00000000, 1'b0, 32'h00000000, 1'b1};
        vt[3] = '{1'b1, 1'b1, 32'h11111111, 1'b1, 32'h00000000, 1'b1};
        vt[4] = '{1'b0, 1'b1, 32'h00000001, 1'b1, 32'h00000000, 1'b1};
        vt[5] = '{1'b0, 1'b1, 32'h00000002, 1'b1, 32'h00000000, 1'b1};
        reset = 1; inp = 0; out = 0; botao = 0; chaves = 0; dado_saida = 0;
        tick();
        chk_on = 1;
        inp = 1;
        tick(); tick();
        chk("rst_pausa", 32'(pausa), 0);
        chk("rst_escreve", 32'(escreve_entrada), 0);
        chk("rst_dado_entrada", dado_entrada, 0);
        chk("rst_display", display, 0);
        chk("rst_valido", 32'(display_valido), 0);
        reset = 0; inp = 0;
        tick();
        chk("rst_ocioso", 32'(pausa), 0);
        repeat (8) tick();

        for (int k = 0; k < 6; k++) begin
            inp = vt[k].inp; out = vt[k].out; dado_saida = vt[k].dado;
            #1;
            chk($sformatf("vet%0d_pausa", k), 32'(pausa), 32'(vt[k].pausa));
            tick();
            chk($sformatf("vet%0d_display", k), display, vt[k].disp);
            chk($sformatf("vet%0d_valido", k), 32'(display_valido), 32'(vt[k].valido));
        end
        inp = 0; out = 0;
        reset = 1; tick(); reset = 0; tick();

        inp = 1; chaves = 16'h00A5;
        #1;
        chk("limpo_pausa_inicio", 32'(pausa), 1);
        repeat (3) tick();
        chk("limpo_pausa_espera", 32'(pausa), 1);
        botao = 1;
        espera_escrita(20, lat);
        chk("limpo_latencia", lat, 7);
        chk("limpo_dado", dado_entrada, 32'h000000A5);
        chk("limpo_pausa_captura", 32'(pausa), 0);
        inp = 0;
        tick();
        chk("limpo_pulso_unico", 32'(escreve_entrada), 0);

        botao = 0;
        repeat (10) tick();
        inp = 1; chaves = 16'h1234;
        repeat (3) tick();
        p0 = n_pulsos;
        for (int k = 0; k < 4; k++) begin
            botao = (k % 2 == 0);
            tick();
        end
        chk("rebote_sem_escrita", n_pulsos - p0, 0);
        botao = 1;
        espera_escrita(20, lat);
        chk("rebote_latencia", lat, 7);
        chk("rebote_dado", dado_entrada, 32'h00001234);
        inp = 0;
        tick();

        botao = 0;
        repeat (10) tick();
        p0 = n_pulsos;
        inp = 1; chaves = 16'h0003;
        repeat (3) tick();
        botao = 1;
        espera_escrita(20, lat);
        chk("seguido_dado1", dado_entrada, 32'h00000003);
        chaves = 16'h0007;
        espera_escrita(15, lat2);
        chk("seguido_preso", lat2, -1);
        chk("seguido_pausa_preso", 32'(pausa), 1);
        botao = 0;
        repeat (10) tick();
        chk("seguido_pausa_solto", 32'(pausa), 1);
        botao = 1;
        espera_escrita(20, lat);
        chk("seguido_latencia2", lat, 7);
        chk("seguido_dado2", dado_entrada, 32'h00000007);
        inp = 0;
        tick();
        chk("seguido_dois_pulsos", n_pulsos - p0, 2);

        botao = 0;
        repeat (10) tick();
        out = 1; dado_saida = 32'hCAFEF00D;
        tick();
        out = 0;
        chk("reset_meio_display_antes", display, 32'hCAFEF00D);
        inp = 1;
        repeat (3) tick();
        chk("reset_meio_pausa_espera", 32'(pausa), 1);
        reset = 1;
        #1;
        chk("reset_meio_pausa_mesmo_ciclo", 32'(pausa), 0);
        p0 = n_pulsos;
        tick();
        chk("reset_meio_pausa", 32'(pausa), 0);
        chk("reset_meio_escreve", 32'(escreve_entrada), 0);
        chk("reset_meio_display", display, 0);
        chk("reset_meio_valido", 32'(display_valido), 0);
        reset = 0; inp = 0; botao = 1;
        repeat (12) tick();
        chk("reset_meio_sem_escrita", n_pulsos - p0, 0);
        chk("reset_meio_ocioso", 32'(pausa), 0);

`ifdef CONTROLE_ES_CONTADOR_EN
        chk("cont_entradas_zero", 32'(contador_entradas), 0);
        for (int k = 1; k <= 256; k++) begin
            out = 1; dado_saida = $urandom;
            tick();
            if (k == 255) chk("cont_saidas_255", 32'(contador_saidas), 255);
        end
        out = 0;
        chk("cont_saidas_volta", 32'(contador_saidas), 0);
`endif

        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            inp = ($urandom_range(0, 2) == 0);
            out = 1'($urandom_range(0, 1));
            dado_saida = $urandom;
            chaves = 16'($urandom);
            if ($urandom_range(0, 7) == 0) botao = ~botao;
            tick();
        end
        chk_on = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
